instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Multicycle fetch/decode/execute controller for the 8-bit processor datapath.
- Fetches instruction bytes from instruction memory over a req/ack handshake and decodes the 3-bit opcode into regWrite / AddSub / destSrc.
- Drives register-file select lines and sequences each instruction through fixed states.
- Store operations go out through a valid/ready output port.

Parameters:
- ADDR_W, 8, instruction memory address width (PC width)
- PROG_LEN, 256, number of instruction bytes; PC reaching PROG_LEN ends the run

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins execution at PC=0 from IDLE or DONE
- imem_req  out  1  instruction-memory read request
- imem_addr  out  ADDR_W  read address (current PC)
- imem_rdata  in  8  read data, valid when imem_ack=1
- imem_ack  in  1  read complete
- reg_write  out  1  register-file write enable, one-cycle pulse in WB
- alu_op  out  3  AddSub code to ALU
- dest_src  out  2  write-back mux select: 00 immediate, 01 register, 10 ALU
- rd_sel  out  2  destination register index
- rs_sel  out  2  source register index
- imm  out  8  immediate for load
- out_valid  out  1  store data valid to output port
- out_ready  in  1  output port accepts
- busy  out  1  high in every state except IDLE/DONE
- done  out  1  high in DONE

Behaviour:
- Instruction byte: [7:5] opcode, [4:3] rd, [2:1] rs, [0] ignored.
- Opcode 000 (load) is followed by one immediate byte at PC+1.
- Decode:
  - 000 load: regWrite 1, alu_op 000, dest_src 00
  - 001 move: 1, 000, 01
  - 010 add: 1, 001, 10
  - 011 sub: 1, 101, 10
  - 100 and: 1, 010, 10
  - 101 or: 1, 011, 10
  - 110 xor: 1, 100, 10
  - 111 store: 0, 000, 01
- Decoded fields are latched in DECODE and held stable until the next DECODE.
- States and transitions:
  - IDLE -> FETCH on start.
  - FETCH: imem_req=1, imem_addr=PC. Waits for imem_ack; on ack, latch byte, PC+=1, -> DECODE.
  - DECODE: opcode 000 -> FETCH_IMM; 111 -> STORE; else -> WB.
  - FETCH_IMM: imem_req=1 at PC. On ack, imm<=rdata, PC+=1, -> WB.
  - WB: reg_write=1 for exactly one cycle. Then -> FETCH, or DONE if PC==PROG_LEN.
  - STORE: out_valid=1 held until out_ready sampled high. Then -> FETCH, or DONE if PC==PROG_LEN. reg_write stays 0.
  - DONE: start -> FETCH with PC cleared to 0.
- Handshakes:
  - imem_req stays high and imem_addr stable until the ack cycle. Ack outside FETCH/FETCH_IMM is ignored.
  - imem_req deasserts in the cycle after ack.
  - out_valid never drops before out_ready.
- Boundaries:
  - If a load sits at the last byte (PC==PROG_LEN after the opcode fetch), the immediate fetch is not issued. The load completes with imm=0x00, then -> DONE.
  - PC arithmetic wraps modulo 2^ADDR_W. PROG_LEN=2^ADDR_W terminates when PC wraps to 0 after having left 0.
  - start is ignored while busy.
- Reset values: state IDLE, PC 0, all outputs 0 (imem_req, reg_write, out_valid, busy, done, alu_op, dest_src, rd_sel, rs_sel, imm). Reset mid-handshake abandons the transaction immediately.
- Minimum latency per instruction with zero-wait ack: ALU/move = 3 cycles, load = 4, store = 3 + out_ready wait.

Optional Feature:
- Macro SEQ_RETIRE_COUNT_EN.
- When defined:
  - Output retired_cnt [15:0] counts completed instructions (increments on the WB reg_write cycle and on the STORE accept cycle).
  - Cleared on reset and on start; saturates at 0xFFFF.
- When undefined: no port and no counter logic.

Test Plan:
- Program {0x00, 0x5A} (load imm to r0), zero-wait ack -> FETCH/DECODE/FETCH_IMM/WB, reg_write pulse once with dest_src=00, rd_sel=0, imm=0x5A; after start: busy=1 for 4 cycles, then done=1 (PROG_LEN=2).
- Byte 0x4A (add rd=1, rs=1) -> alu_op=001, dest_src=10, rd_sel=1, rs_sel=1, reg_write high exactly 1 cycle.
- Byte 0xE4 (store rs=2), out_ready low 5 cycles then high -> out_valid high 6 cycles, reg_write never asserts, next FETCH follows the accept cycle.
- imem_ack delayed 3 cycles -> imem_req high 4 cycles with constant imem_addr, PC increments once.
- PROG_LEN=1, program {0x00} -> no second fetch, WB with imm=0x00, then DONE.
- reset asserted during FETCH_IMM -> next cycle IDLE, PC=0, all outputs 0; a later start refetches from address 0.

Source files
------------

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multicycle fetch/decode/execute controller for the 8-bit datapath
// Optional feature macro SEQ_RETIRE_COUNT_EN adds a saturating retired-instruction counter.
module instr_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int PROG_LEN = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [7:0]        imem_rdata,
  input  logic              imem_ack,
  output logic              reg_write,
  output logic [2:0]        alu_op,
  output logic [1:0]        dest_src,
  output logic [1:0]        rd_sel,
  output logic [1:0]        rs_sel,
  output logic [7:0]        imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
`ifdef SEQ_RETIRE_COUNT_EN
  ,
  output logic [15:0]       retired_cnt
`endif
);

  // Truncation makes PROG_LEN == 2**ADDR_W compare against a wrapped PC of 0; the
  // compare is only made after at least one increment, so PC has left 0 by then.
  localparam logic [ADDR_W-1:0] END_PC = ADDR_W'(PROG_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_FETCH_IMM, S_WB, S_STORE, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:1]        instr_q, instr_d;
  logic              rw_q, rw_d;
  logic [2:0]        alu_op_q, alu_op_d;
  logic [1:0]        dest_src_q, dest_src_d;
  logic [1:0]        rd_q, rd_d;
  logic [1:0]        rs_q, rs_d;
  logic [7:0]        imm_q, imm_d;
  logic              at_end;

  // {regWrite, alu_op[2:0], dest_src[1:0]}
  function automatic logic [5:0] decode_op(input logic [2:0] op);
    case (op)
      3'b000:  decode_op = {1'b1, 3'b000, 2'b00};
      3'b001:  decode_op = {1'b1, 3'b000, 2'b01};
      3'b010:  decode_op = {1'b1, 3'b001, 2'b10};
      3'b011:  decode_op = {1'b1, 3'b101, 2'b10};
      3'b100:  decode_op = {1'b1, 3'b010, 2'b10};
      3'b101:  decode_op = {1'b1, 3'b011, 2'b10};
      3'b110:  decode_op = {1'b1, 3'b100, 2'b10};
      default: decode_op = {1'b0, 3'b000, 2'b01};
    endcase
  endfunction

  assign at_end = (pc_q == END_PC);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      instr_q    <= '0;
      rw_q       <= 1'b0;
      alu_op_q   <= '0;
      dest_src_q <= '0;
      rd_q       <= '0;
      rs_q       <= '0;
      imm_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      rw_q       <= rw_d;
      alu_op_q   <= alu_op_d;
      dest_src_q <= dest_src_d;
      rd_q       <= rd_d;
      rs_q       <= rs_d;
      imm_q      <= imm_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    rw_d       = rw_q;
    alu_op_d   = alu_op_q;
    dest_src_d = dest_src_q;
    rd_d       = rd_q;
    rs_d       = rs_q;
    imm_d      = imm_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata[7:1];
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        {rw_d, alu_op_d, dest_src_d} = decode_op(instr_q[7:5]);
        rd_d  = instr_q[4:3];
        rs_d  = instr_q[2:1];
        imm_d = 8'h00;
        // A load whose opcode is the last program byte has no immediate to fetch.
        if (instr_q[7:5] == 3'b000)      state_d = at_end ? S_WB : S_FETCH_IMM;
        else if (instr_q[7:5] == 3'b111) state_d = S_STORE;
        else                             state_d = S_WB;
      end
      S_FETCH_IMM: begin
        if (imem_ack) begin
          imm_d   = imem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_WB;
        end
      end
      S_WB: begin
        state_d = at_end ? S_DONE : S_FETCH;
      end
      S_STORE: begin
        if (out_ready) state_d = at_end ? S_DONE : S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_req  = (state_q == S_FETCH) || (state_q == S_FETCH_IMM);
  assign imem_addr = pc_q;
  assign reg_write = (state_q == S_WB) && rw_q;
  assign out_valid = (state_q == S_STORE);
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign alu_op    = alu_op_q;
  assign dest_src  = dest_src_q;
  assign rd_sel    = rd_q;
  assign rs_sel    = rs_q;
  assign imm       = imm_q;

`ifdef SEQ_RETIRE_COUNT_EN
  logic [15:0] retired_q;
  logic        retire;

  assign retire = (state_q == S_WB) || ((state_q == S_STORE) && out_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
    end else if (!busy && start) begin
      retired_q <= '0;
    end else if (retire && (retired_q != 16'hFFFF)) begin
      retired_q <= retired_q + 16'd1;
    end
  end

  assign retired_cnt = retired_q;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - table-driven and directed bench for instr_sequencer
module tb_instr_sequencer;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, start_b, out_ready;
  logic       req, ack, reg_write, out_valid, busy, done;
  logic [7:0] addr, rdata, imm;
  logic [2:0] alu_op;
  logic [1:0] dest_src, rd_sel, rs_sel;

  logic       req1, reg_write1, out_valid1, busy1, done1;
  logic [7:0] addr1, rdata1, imm1;
  logic [2:0] alu_op1;
  logic [1:0] dest_src1, rd_sel1, rs_sel1;

  logic       req2, reg_write2, out_valid2, busy2, done2;
  logic [1:0] addr2;
  logic [7:0] imm2;
  logic [2:0] alu_op2;
  logic [1:0] dest_src2, rd_sel2, rs_sel2;
  logic       one;

`ifdef SEQ_RETIRE_COUNT_EN
  logic [15:0] rc0, rc1, rc2;
`endif

  logic [7:0] mem0 [256];
  int         ack_delay, wait_cnt;

  assign one    = 1'b1;
  assign rdata  = mem0[addr];
  assign ack    = req && (wait_cnt >= ack_delay);
  assign rdata1 = (addr1 == 8'd0) ? 8'h00 : 8'h99;

  always @(posedge clk) begin
    if (reset || !req || ack) wait_cnt <= 0;
    else                      wait_cnt <= wait_cnt + 1;
  end

  instr_sequencer #(.ADDR_W(8), .PROG_LEN(2)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_req(req), .imem_addr(addr), .imem_rdata(rdata), .imem_ack(ack),
    .reg_write(reg_write), .alu_op(alu_op), .dest_src(dest_src),
    .rd_sel(rd_sel), .rs_sel(rs_sel), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
`ifdef SEQ_RETIRE_COUNT_EN
    , .retired_cnt(rc0)
`endif
  );

  instr_sequencer #(.ADDR_W(8), .PROG_LEN(1)) dut1 (
    .clk(clk), .reset(reset), .start(start_b),
    .imem_req(req1), .imem_addr(addr1), .imem_rdata(rdata1), .imem_ack(req1),
    .reg_write(reg_write1), .alu_op(alu_op1), .dest_src(dest_src1),
    .rd_sel(rd_sel1), .rs_sel(rs_sel1), .imm(imm1),
    .out_valid(out_valid1), .out_ready(one), .busy(busy1), .done(done1)
`ifdef SEQ_RETIRE_COUNT_EN
    , .retired_cnt(rc1)
`endif
  );

  instr_sequencer #(.ADDR_W(2), .PROG_LEN(4)) dut2 (
    .clk(clk), .reset(reset), .start(start_b),
    .imem_req(req2), .imem_addr(addr2), .imem_rdata(8'h2C), .imem_ack(req2),
    .reg_write(reg_write2), .alu_op(alu_op2), .dest_src(dest_src2),
    .rd_sel(rd_sel2), .rs_sel(rs_sel2), .imm(imm2),
    .out_valid(out_valid2), .out_ready(one), .busy(busy2), .done(done2)
`ifdef SEQ_RETIRE_COUNT_EN
    , .retired_cnt(rc2)
`endif
  );

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    int         exp_wb;
    int         exp_ov;
    int         exp_busy;
    logic [2:0] alu;
    logic [1:0] dst;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] immv;
    bit         chk_imm;
  } vec_t;

  vec_t vecs [9];

  int         n_busy, n_wb, n_ov, n_req, n_ack, n_rwlong, n_addrchg, n_drop, n_nextbad;
  int         ready_wait;
  logic [7:0] ack_addr [4];
  logic [2:0] cap_alu;
  logic [1:0] cap_dst, cap_rd, cap_rs;
  logic [7:0] cap_imm;

  // Starts the main DUT and observes it cycle by cycle until done.
  task automatic run_main(input int max_cyc);
    logic       prev_rw, prev_req, prev_ack, prev_ov, prev_rdy, acc_pending;
    logic [7:0] prev_addr;
    bit         got;
    n_busy = 0; n_wb = 0; n_ov = 0; n_req = 0; n_ack = 0;
    n_rwlong = 0; n_addrchg = 0; n_drop = 0; n_nextbad = 0;
    for (int k = 0; k < 4; k++) ack_addr[k] = 8'hFF;
    prev_rw = 0; prev_req = 0; prev_ack = 0; prev_ov = 0; prev_rdy = 0;
    prev_addr = 0; acc_pending = 0; got = 0;
    out_ready = 0;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      if (acc_pending && !req) n_nextbad++;
      acc_pending = 0;
      if (busy) n_busy++;
      if (req) begin
        n_req++;
        if (prev_req && !prev_ack && addr != prev_addr) n_addrchg++;
        if (ack) begin
          if (n_ack < 4) ack_addr[n_ack] = addr;
          n_ack++;
        end
      end
      if (reg_write) begin
        n_wb++;
        if (prev_rw) n_rwlong++;
      end
      if (out_valid) begin
        n_ov++;
        out_ready = (n_ov > ready_wait);
        start = (n_ov == 2);
        acc_pending = out_ready;
      end else begin
        out_ready = 0;
        start = 0;
      end
      if (prev_ov && !prev_rdy && !out_valid) n_drop++;
      if ((reg_write || out_valid) && !got) begin
        got = 1;
        cap_alu = alu_op; cap_dst = dest_src; cap_rd = rd_sel; cap_rs = rs_sel; cap_imm = imm;
      end
      prev_rw = reg_write; prev_req = req; prev_ack = ack; prev_addr = addr;
      prev_ov = out_valid; prev_rdy = out_ready;
      @(posedge clk); #1;
    end
    start = 0;
    out_ready = 0;
    check("run_done", done, 1);
  endtask

  initial begin
    int  b1_busy, b1_wb, b1_ack, b2_busy, b2_wb, b2_ack;
    logic [7:0] b1_imm;
    bit  found;

    vecs[0] = '{8'h00, 8'h5A, 1, 0, 4, 3'b000, 2'b00, 2'd0, 2'd0, 8'h5A, 1'b1};
    vecs[1] = '{8'h1E, 8'hC3, 1, 0, 4, 3'b000, 2'b00, 2'd3, 2'd3, 8'hC3, 1'b1};
    vecs[2] = '{8'h2C, 8'h2C, 2, 0, 6, 3'b000, 2'b01, 2'd1, 2'd2, 8'h00, 1'b0};
    vecs[3] = '{8'h4A, 8'h4A, 2, 0, 6, 3'b001, 2'b10, 2'd1, 2'd1, 8'h00, 1'b0};
    vecs[4] = '{8'h75, 8'h75, 2, 0, 6, 3'b101, 2'b10, 2'd2, 2'd2, 8'h00, 1'b0};
    vecs[5] = '{8'h98, 8'h98, 2, 0, 6, 3'b010, 2'b10, 2'd3, 2'd0, 8'h00, 1'b0};
    vecs[6] = '{8'hA6, 8'hA6, 2, 0, 6, 3'b011, 2'b10, 2'd0, 2'd3, 8'h00, 1'b0};
    vecs[7] = '{8'hD2, 8'hD2, 2, 0, 6, 3'b100, 2'b10, 2'd2, 2'd1, 8'h00, 1'b0};
    vecs[8] = '{8'hE4, 8'hE4, 0, 2, 6, 3'b000, 2'b01, 2'd0, 2'd2, 8'h00, 1'b0};

    for (int k = 0; k < 256; k++) mem0[k] = 8'h00;
    reset = 1; start = 0; start_b = 0; out_ready = 0; ack_delay = 0; ready_wait = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", {req, reg_write, out_valid, busy, done}, 0);
    check("rst_fields", {alu_op, dest_src, rd_sel, rs_sel, imm, addr}, 0);
    reset = 0;
    @(posedge clk); #1;
    check("idle_busy", {busy, done, req}, 0);

    // Load at the last byte (PROG_LEN=1) and PC wrap (ADDR_W=2, PROG_LEN=4)
    b1_busy = 0; b1_wb = 0; b1_ack = 0; b2_busy = 0; b2_wb = 0; b2_ack = 0; b1_imm = 8'hEE;
    start_b = 1;
    @(posedge clk); #1;
    start_b = 0;
    for (int c = 0; c < 60 && !(done1 && done2); c++) begin
      if (busy1) b1_busy++;
      if (req1) b1_ack++;
      if (reg_write1) begin b1_wb++; b1_imm = imm1; end
      if (busy2) b2_busy++;
      if (req2) b2_ack++;
      if (reg_write2) b2_wb++;
      @(posedge clk); #1;
    end
    check("last_done", done1, 1);
    check("last_fetches", b1_ack, 1);
    check("last_wb", b1_wb, 1);
    check("last_imm", b1_imm, 8'h00);
    check("last_busy", b1_busy, 3);
    check("wrap_done", done2, 1);
    check("wrap_wb", b2_wb, 4);
    check("wrap_fetches", b2_ack, 4);
    check("wrap_busy", b2_busy, 12);

    for (int i = 0; i < 9; i++) begin
      mem0[0] = vecs[i].b0;
      mem0[1] = vecs[i].b1;
      ack_delay = 0;
      ready_wait = 0;
      run_main(60);
      check($sformatf("v%0d_wb", i), n_wb, vecs[i].exp_wb);
      check($sformatf("v%0d_ov", i), n_ov, vecs[i].exp_ov);
      check($sformatf("v%0d_busy", i), n_busy, vecs[i].exp_busy);
      check($sformatf("v%0d_alu", i), cap_alu, vecs[i].alu);
      check($sformatf("v%0d_dst", i), cap_dst, vecs[i].dst);
      check($sformatf("v%0d_rd", i), cap_rd, vecs[i].rd);
      check($sformatf("v%0d_rs", i), cap_rs, vecs[i].rs);
      if (vecs[i].chk_imm) check($sformatf("v%0d_imm", i), cap_imm, vecs[i].immv);
      check($sformatf("v%0d_acks", i), n_ack, 2);
      check($sformatf("v%0d_addr0", i), ack_addr[0], 8'h00);
      check($sformatf("v%0d_rwlong", i), n_rwlong, 0);
    end

    // Slow instruction memory: request held 4 cycles per fetch with a steady address
    mem0[0] = 8'h4A; mem0[1] = 8'h4A;
    ack_delay = 3;
    run_main(80);
    check("slow_req_cycles", n_req, 8);
    check("slow_acks", n_ack, 2);
    check("slow_addr_stable", n_addrchg, 0);
    check("slow_addr0", ack_addr[0], 8'h00);
    check("slow_addr1", ack_addr[1], 8'h01);
    check("slow_busy", n_busy, 12);

    // Store back-pressured 5 cycles, with a start pulse while busy
    mem0[0] = 8'hE4; mem0[1] = 8'h4A;
    ack_delay = 0;
    ready_wait = 5;
    run_main(80);
    check("st_valid_cycles", n_ov, 6);
    check("st_wb", n_wb, 1);
    check("st_rs", cap_rs, 2'd2);
    check("st_no_drop", n_drop, 0);
    check("st_next_fetch", n_nextbad, 0);
    check("st_busy", n_busy, 11);
    check("st_acks", n_ack, 2);
    check("st_addr1", ack_addr[1], 8'h01);
    ready_wait = 0;

    // Reset while the immediate fetch is outstanding
    mem0[0] = 8'h1E; mem0[1] = 8'h77;
    ack_delay = 3;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    found = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (req && addr == 8'h01) found = 1;
      else begin @(posedge clk); #1; end
    end
    check("rst_mid_reached", found, 1);
    reset = 1;
    @(posedge clk); #1;
    check("rst_mid_out", {req, reg_write, out_valid, busy, done}, 0);
    check("rst_mid_fields", {alu_op, dest_src, rd_sel, rs_sel, imm, addr}, 0);
    reset = 0;
    @(posedge clk); #1;
    check("rst_mid_idle", {busy, req}, 0);
    ack_delay = 0;
    run_main(60);
    check("refetch_addr0", ack_addr[0], 8'h00);
    check("refetch_acks", n_ack, 2);
    check("refetch_imm", cap_imm, 8'h77);
    check("refetch_rd", cap_rd, 2'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
